// File: rtl/apu_sram_pkg.sv
// Shared types and helpers for the APU SRAM arbiter: FSM states, grant ids,
// and byte-lane extraction from the 16-bit SRAM word.
package apu_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_END    = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int CNT_W = 4;

  function automatic logic [7:0] lane_sel(input logic i_hi, input logic [15:0] i_word);
    return i_hi ? i_word[15:8] : i_word[7:0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On contention the port that was not granted
// last wins; the last-grant register lives in the parent.
module rr_arb2
  import apu_sram_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  input  logic enable,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = enable & (req_a | req_b);
    grant_id    = PORT_A;
    if (req_a && req_b) begin
      grant_id = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/apu_sram_arbiter.sv
// Shares one 16-bit async SRAM between two byte-wide requesters (A: SPC700,
// B: DSP/loader) and sequences every SRAM cycle with registered controls.
//
// state     | meaning
// ST_IDLE   | sample requests, grant one port
// ST_SETUP  | CE, address, lane enable (and write data drive) asserted
// ST_STROBE | OE or WE low for STROBE_CYCLES cycles; read data captured last cycle
// ST_END    | strobe released, address/CE/data held, ack pulsed
module apu_sram_arbiter
  import apu_sram_pkg::*;
#(
  parameter int ADDR_W        = 19,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic              busy,
  output logic [ADDR_W-2:0] SRAM_ADDR,
  output logic              SRAM_CEn,
  output logic              SRAM_OEn,
  output logic              SRAM_WEn,
  output logic              SRAM_LBn,
  output logic              SRAM_UBn,
  output logic              SRAM_DEn,
  output logic [15:0]       SRAM_Dout,
  input  logic [15:0]       SRAM_Din
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_last_grant, w_last_nxt;
  logic               r_port, w_port_nxt;
  logic               r_we, w_we_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [7:0]         r_wdata, w_wdata_nxt;

  logic w_idle, w_grant_valid, w_grant_id;
  logic w_active, w_cen_nxt, w_oen_nxt, w_wen_nxt, w_lbn_nxt, w_ubn_nxt, w_den_nxt;
  logic w_a_ack_nxt, w_b_ack_nxt, w_capture;

  assign w_idle = (r_state == ST_IDLE);
  assign busy   = ~w_idle;

  rr_arb2 u_arb (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_grant  (r_last_grant),
    .enable      (w_idle),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // Access attributes are only reloaded on a grant; they are frozen until END.
  always_comb begin
    w_port_nxt  = r_port;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_last_nxt  = r_last_grant;
    if (w_grant_valid) begin
      w_port_nxt  = w_grant_id;
      w_we_nxt    = (w_grant_id == PORT_B) ? b_we    : a_we;
      w_addr_nxt  = (w_grant_id == PORT_B) ? b_addr  : a_addr;
      w_wdata_nxt = (w_grant_id == PORT_B) ? b_wdata : a_wdata;
      w_last_nxt  = w_grant_id;
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= PORT_B;
      r_port       <= PORT_A;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_nxt;
      r_port       <= w_port_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_state_nxt = ST_STROBE;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_STROBE: begin
        if (r_cnt == '0) w_state_nxt = ST_END;
        else             w_cnt_nxt   = r_cnt - CNT_ONE;
      end
      ST_END: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pad controls are decoded from the next state so they register cleanly.
  always_comb begin
    w_active    = (w_state_nxt != ST_IDLE);
    w_cen_nxt   = ~w_active;
    w_lbn_nxt   = ~(w_active & ~w_addr_nxt[0]);
    w_ubn_nxt   = ~(w_active &  w_addr_nxt[0]);
    w_oen_nxt   = ~((w_state_nxt == ST_STROBE) & ~w_we_nxt);
    w_wen_nxt   = ~((w_state_nxt == ST_STROBE) &  w_we_nxt);
    w_den_nxt   = ~(w_active & w_we_nxt);
    w_a_ack_nxt = (w_state_nxt == ST_END) & (r_port == PORT_A);
    w_b_ack_nxt = (w_state_nxt == ST_END) & (r_port == PORT_B);
    w_capture   = (r_state == ST_STROBE) & (r_cnt == '0) & ~r_we;
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      SRAM_CEn  <= 1'b1;
      SRAM_OEn  <= 1'b1;
      SRAM_WEn  <= 1'b1;
      SRAM_LBn  <= 1'b1;
      SRAM_UBn  <= 1'b1;
      SRAM_DEn  <= 1'b1;
      SRAM_ADDR <= '0;
      SRAM_Dout <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      SRAM_CEn <= w_cen_nxt;
      SRAM_OEn <= w_oen_nxt;
      SRAM_WEn <= w_wen_nxt;
      SRAM_LBn <= w_lbn_nxt;
      SRAM_UBn <= w_ubn_nxt;
      SRAM_DEn <= w_den_nxt;
      a_ack    <= w_a_ack_nxt;
      b_ack    <= w_b_ack_nxt;
      if (w_state_nxt == ST_SETUP) begin
        SRAM_ADDR <= w_addr_nxt[ADDR_W-1:1];
        if (w_we_nxt) SRAM_Dout <= {w_wdata_nxt, w_wdata_nxt};
      end
      if (w_capture) begin
        if (r_port == PORT_A) a_rdata <= lane_sel(r_addr[0], SRAM_Din);
        else                  b_rdata <= lane_sel(r_addr[0], SRAM_Din);
      end
    end
  end

endmodule

// File: tb/tb_apu_sram_arbiter.sv
// Bench for apu_sram_arbiter: SRAM model, scoreboard of expected acks, and a
// second instance with a single-cycle strobe.
module tb_apu_sram_arbiter;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic        a_req, a_we, b_req, b_we;
  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, b_ack, busy;
  logic [7:0]  a_rdata, b_rdata;
  logic [17:0] sram_addr;
  logic        ce, oe, we_n, lb, ub, den;
  logic [15:0] dout, din;

  logic [15:0] mem [0:262143];

  apu_sram_arbiter #(.ADDR_W(19), .STROBE_CYCLES(S)) dut (
    .m_clock(clk), .p_reset(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .SRAM_ADDR(sram_addr),
    .SRAM_CEn(ce), .SRAM_OEn(oe), .SRAM_WEn(we_n), .SRAM_LBn(lb), .SRAM_UBn(ub),
    .SRAM_DEn(den), .SRAM_Dout(dout), .SRAM_Din(din)
  );

  assign din = (!ce && !oe) ? mem[sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!ce && !we_n && !den) begin
      if (!lb) mem[sram_addr][7:0]  <= dout[7:0];
      if (!ub) mem[sram_addr][15:8] <= dout[15:8];
    end
  end

  // Single-cycle strobe instance; only port A is exercised.
  logic        s1_a_req, s1_a_we, s1_b_req, s1_b_we;
  logic [18:0] s1_a_addr, s1_b_addr;
  logic [7:0]  s1_a_wdata, s1_b_wdata;
  logic        s1_a_ack, s1_b_ack, s1_busy;
  logic [7:0]  s1_a_rdata, s1_b_rdata;
  logic [17:0] s1_addr;
  logic        s1_ce, s1_oe, s1_we, s1_lb, s1_ub, s1_den;
  logic [15:0] s1_dout, s1_din;

  apu_sram_arbiter #(.ADDR_W(19), .STROBE_CYCLES(1)) dut_s1 (
    .m_clock(clk), .p_reset(rst),
    .a_req(s1_a_req), .a_we(s1_a_we), .a_addr(s1_a_addr), .a_wdata(s1_a_wdata),
    .a_ack(s1_a_ack), .a_rdata(s1_a_rdata),
    .b_req(s1_b_req), .b_we(s1_b_we), .b_addr(s1_b_addr), .b_wdata(s1_b_wdata),
    .b_ack(s1_b_ack), .b_rdata(s1_b_rdata),
    .busy(s1_busy), .SRAM_ADDR(s1_addr),
    .SRAM_CEn(s1_ce), .SRAM_OEn(s1_oe), .SRAM_WEn(s1_we), .SRAM_LBn(s1_lb), .SRAM_UBn(s1_ub),
    .SRAM_DEn(s1_den), .SRAM_Dout(s1_dout), .SRAM_Din(s1_din)
  );

  assign s1_din = (!s1_ce && !s1_oe && s1_addr == 18'h3) ? 16'h1234 : 16'h0000;

  typedef struct {
    logic        port;
    logic        rd;
    logic [17:0] waddr;
    logic        hi;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Protocol monitor and scoreboard consumer.
  initial begin
    int   oe_c, wr_c, de_c;
    exp_t e;
    oe_c = 0; wr_c = 0; de_c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        oe_c = 0; wr_c = 0; de_c = 0;
      end else begin
        chk("oe_we_excl", 32'(!oe && !we_n), 0);
        chk("den_idle", 32'(ce && !den), 0);
        if (ce) begin
          oe_c = 0; wr_c = 0; de_c = 0;
        end else begin
          if (!oe)   oe_c++;
          if (!we_n) wr_c++;
          if (!den)  de_c++;
        end
        if (a_ack || b_ack) begin
          ack_cyc.push_back(cyc);
          chk("dbl_ack", 32'(a_ack && b_ack), 0);
          chk("ack_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant_port", 32'(b_ack), 32'(e.port));
            chk("sram_addr", 32'(sram_addr), 32'(e.waddr));
            chk("lane_en", {30'd0, ub, lb}, e.hi ? 32'h1 : 32'h2);
            chk("busy_active", 32'(busy), 1);
            if (e.rd) begin
              chk("rdata", 32'(e.port ? b_rdata : a_rdata), 32'(e.data));
              chk("oe_len", oe_c, S);
              chk("we_len_rd", wr_c, 0);
              chk("den_rd", 32'(den), 1);
            end else begin
              chk("we_len", wr_c, S);
              chk("oe_len_wr", oe_c, 0);
              chk("den_len", de_c, S + 2);
              chk("dout", 32'(dout), {16'd0, e.data, e.data});
            end
          end
        end
      end
    end
  end

  task automatic wait_ack(input logic port, output bit got, output int ca);
    got = 0;
    ca  = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) begin
        got = 1;
        ca  = cyc;
      end
    end
    chk("ack_seen", 32'(got), 1);
  endtask

  // Call #1 after a rising edge; returns #1 after the edge that samples ack.
  task automatic access(input logic port, input logic we, input logic [18:0] addr,
                        input logic [7:0] wd, input logic [7:0] rexp,
                        input bit push, input bit lat);
    int   c0, ca;
    bit   got;
    exp_t e;
    if (push) begin
      e.port  = port;
      e.rd    = !we;
      e.waddr = addr[18:1];
      e.hi    = addr[0];
      e.data  = we ? wd : rexp;
      sb.push_back(e);
    end
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    c0 = cyc;
    wait_ack(port, got, ca);
    if (lat) chk("latency", ca - c0, S + 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n0, c0, ca, oe1;
    bit   got;

    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    s1_a_req = 0; s1_a_we = 0; s1_a_addr = '0; s1_a_wdata = '0;
    s1_b_req = 0; s1_b_we = 0; s1_b_addr = '0; s1_b_wdata = '0;
    mem[18'h02] = 16'hBEEF;
    mem[18'h08] = 16'hC3A7;
    mem[18'h10] = 16'h2211;
    mem[18'h11] = 16'h4433;
    mem[18'h20] = 16'h6655;
    mem[18'h21] = 16'h8899;
    mem[18'h80] = 16'h1111;
    mem[18'hF8] = 16'h0000;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {26'd0, ce, oe, we_n, lb, ub, den}, 32'h3F);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ack", {30'd0, a_ack, b_ack}, 0);
    chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous requests out of reset: A first, then strict alternation.
    e = '{port: 1'b0, rd: 1'b1, waddr: 18'h10, hi: 1'b0, data: 8'h11}; sb.push_back(e);
    e = '{port: 1'b1, rd: 1'b1, waddr: 18'h20, hi: 1'b1, data: 8'h66}; sb.push_back(e);
    e = '{port: 1'b0, rd: 1'b1, waddr: 18'h11, hi: 1'b1, data: 8'h44}; sb.push_back(e);
    e = '{port: 1'b1, rd: 1'b0, waddr: 18'h21, hi: 1'b0, data: 8'h77}; sb.push_back(e);
    n0 = ack_cyc.size();
    fork
      begin
        access(1'b0, 1'b0, 19'h20, 8'h00, 8'h11, 1'b0, 1'b0);
        access(1'b0, 1'b0, 19'h23, 8'h00, 8'h44, 1'b0, 1'b0);
        a_req = 1'b0;
      end
      begin
        access(1'b1, 1'b0, 19'h41, 8'h00, 8'h66, 1'b0, 1'b0);
        access(1'b1, 1'b1, 19'h42, 8'h77, 8'h00, 1'b0, 1'b0);
        b_req = 1'b0;
      end
    join
    chk("rr_acks", ack_cyc.size() - n0, 4);
    for (int i = 1; i < 4; i++) begin
      if (ack_cyc.size() > n0 + i) chk("ack_gap", ack_cyc[n0+i] - ack_cyc[n0+i-1], S + 3);
    end
    chk("mem_rr_wr", 32'(mem[18'h21]), 32'h8877);
    chk("busy_idle", 32'(busy), 0);

    // Port A upper-lane read.
    access(1'b0, 1'b0, 19'h00005, 8'h00, 8'hBE, 1'b1, 1'b1);
    a_req = 1'b0;

    // Port B write then read back.
    access(1'b1, 1'b1, 19'h00100, 8'h5A, 8'h00, 1'b1, 1'b1);
    b_req = 1'b0;
    chk("rdata_hold_wr", 32'(b_rdata), 32'h66);
    chk("mem_wr", 32'(mem[18'h80]), 32'h115A);
    access(1'b1, 1'b0, 19'h00100, 8'h00, 8'h5A, 1'b1, 1'b1);
    b_req = 1'b0;

    // Port A back-to-back reads with req held.
    access(1'b0, 1'b0, 19'h10, 8'h00, 8'hA7, 1'b1, 1'b1);
    access(1'b0, 1'b0, 19'h11, 8'h00, 8'hC3, 1'b1, 1'b1);
    a_req = 1'b0;
    chk("rdata_hold_b", 32'(b_rdata), 32'h5A);

    // Reset in the middle of a write strobe, req held across it.
    e = '{port: 1'b1, rd: 1'b0, waddr: 18'hF8, hi: 1'b0, data: 8'h3C}; sb.push_back(e);
    b_req = 1'b1; b_we = 1'b1; b_addr = 19'h1F0; b_wdata = 8'h3C;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!we_n) got = 1;
    end
    chk("we_low_seen", 32'(got), 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_ctrl", {28'd0, we_n, ce, den, oe}, 32'hF);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(b_ack), 0);
    @(posedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    c0 = cyc;
    wait_ack(1'b1, got, ca);
    chk("abort_latency", ca - c0, S + 2);
    @(posedge clk);
    #1;
    b_req = 1'b0;
    chk("abort_mem", 32'(mem[18'hF8]), 32'h003C);

    // Single-cycle strobe instance.
    s1_a_req = 1'b1; s1_a_we = 1'b0; s1_a_addr = 19'h7;
    c0  = cyc;
    oe1 = 0;
    got = 0;
    ca  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!s1_oe) oe1++;
      if (s1_a_ack) begin
        got = 1;
        ca  = cyc;
      end
    end
    chk("s1_ack_seen", 32'(got), 1);
    chk("s1_latency", ca - c0, 3);
    chk("s1_oe_len", oe1, 1);
    chk("s1_rdata", 32'(s1_a_rdata), 32'h12);
    @(posedge clk);
    #1;
    s1_a_req = 1'b0;

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
